// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side engine for a single-port synchronous block RAM. A start command
// requests `len` sequential words beginning at `start_addr`; the block issues
// the reads, absorbs the RAM's one-cycle read latency through a small
// two-entry FIFO, and presents the words on a valid/ready stream with a
// last-word marker. It never writes the RAM.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle command pulse, only looked at while idle
//   start_addr  first address of the command
//   len         word count, 0 .. 2^ADDR_W
//   busy        high while a command is streaming
//   done        one-cycle pulse when a command completes
//   ram_we      RAM write enable, always 0
//   ram_en      RAM read strobe
//   ram_addr    RAM read address, meaningful while ram_en=1
//   ram_dout    RAM read data, valid the cycle after ram_en=1
//   m_valid     output word valid
//   m_ready     consumer ready
//   m_data      output word (FIFO head)
//   m_last      marks the final word of the command
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_mem0_q, fifo_mem1_q;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credit;
    logic [2:0]        credit_after_pop;

    // The word read last cycle lands in the FIFO this cycle.
    assign push    = inflight_q;
    assign m_valid = (count_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = rd_ptr_q ? fifo_mem1_q : fifo_mem0_q;
    assign m_last  = m_valid && (out_cnt_q == CNT_ONE);

    // A new read is only issued if, after this cycle's pop, the FIFO plus
    // the read still in flight leave room for it. This keeps the FIFO at
    // two entries yet still sustains one word per cycle with m_ready high.
    assign credit           = {1'b0, count_q} + {2'b00, inflight_q};
    assign credit_after_pop = credit - {2'b00, pop};
    assign issue            = (state_q == S_RUN) && (issue_cnt_q != '0)
                              && (credit_after_pop < 3'd2);

    assign ram_we   = 1'b0;
    assign ram_en   = issue;
    assign ram_addr = rd_addr_q;

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_FINISH);

    // Command FSM plus the address/issue/output counters.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = S_RUN;
                        rd_addr_d   = start_addr;
                        issue_cnt_d = len;
                        out_cnt_d   = len;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + ADDR_ONE;
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q - CNT_ONE;
                    if (out_cnt_q == CNT_ONE) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= issue;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage is cleared on reset so m_data reads 0 and no stale word survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem0_q <= '0;
            fifo_mem1_q <= '0;
        end else if (push) begin
            if (wr_ptr_q) begin
                fifo_mem1_q <= ram_dout;
            end else begin
                fifo_mem0_q <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A behavioural synchronous RAM
// feeds the DUT; a table of commands is replayed, each with hand-computed
// first/last words, and every handshaken word is compared to the RAM image.
// Reset mid-command is exercised as a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       ram_we;
    logic       ram_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_dout;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    int errors;
    int checks;

    logic [7:0] memory [16];

    typedef struct {
        bit         fillXor;
        logic [3:0] startAddr;
        logic [4:0] len;
        bit         randReady;
        int         secondAt;
        int         expWords;
        logic [7:0] expFirst;
        logic [7:0] expLast;
    } vec_t;

    vec_t vecs [6];

    bram_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_we     (ram_we),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM with one cycle of read latency.
    initial ram_dout = 8'h00;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= memory[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic loadMemory(input bit fillXor);
        for (int a = 0; a < 16; a++) begin
            memory[a] = 8'(a) ^ 8'h5A;
        end
        if (!fillXor) begin
            memory[0] = 8'hAA;
            memory[1] = 8'hBB;
            memory[2] = 8'hCC;
        end
    endtask

    // Runs one command and checks every cycle until a few cycles past done.
    task automatic applyStimulus(input vec_t v);
        int idx;
        int issued;
        int got;
        int doneCnt;
        int doneIdx;
        int firstEnIdx;
        int firstValidIdx;
        int firstHsIdx;
        int lastHsIdx;
        int extra;
        bit holding;
        logic [7:0] held;
        logic [7:0] firstData;
        logic [7:0] lastData;
        logic [3:0] expAddr;
        logic [3:0] dataAddr;

        idx = 0; issued = 0; got = 0; doneCnt = 0; doneIdx = -1;
        firstEnIdx = -1; firstValidIdx = -1; firstHsIdx = -1; lastHsIdx = -1;
        extra = 0; holding = 1'b0; held = 8'h00;
        firstData = 8'h00; lastData = 8'h00;

        loadMemory(v.fillXor);
        @(negedge clk);
        start      = 1'b1;
        start_addr = v.startAddr;
        len        = v.len;
        m_ready    = 1'b1;

        while (idx < 200 && extra < 3) begin
            @(negedge clk);
            idx++;
            start = (idx == v.secondAt);
            if (start) begin
                start_addr = 4'd9;
                len        = 5'd3;
            end
            m_ready = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (ram_en) begin
                if (firstEnIdx < 0) firstEnIdx = idx;
                expAddr = v.startAddr + 4'(issued);
                checkOutput("ramAddr", 32'(ram_addr), 32'(expAddr));
                issued++;
            end
            if (holding) begin
                checkOutput("stallValid", 32'(m_valid), 32'd1);
                checkOutput("stallData", 32'(m_data), 32'(held));
            end
            holding = 1'b0;
            if (m_valid && firstValidIdx < 0) firstValidIdx = idx;
            if (m_valid && m_ready) begin
                dataAddr = v.startAddr + 4'(got);
                checkOutput("wordData", 32'(m_data), 32'(memory[dataAddr]));
                checkOutput("wordLast", 32'(m_last), 32'(got == int'(v.len) - 1));
                if (got == 0) begin
                    firstData  = m_data;
                    firstHsIdx = idx;
                end
                lastData  = m_data;
                lastHsIdx = idx;
                got++;
            end else if (m_valid) begin
                holding = 1'b1;
                held    = m_data;
            end
            checkOutput("creditBound", 32'(issued - got <= 2), 32'd1);
            if (doneCnt == 0 && !done && v.len != 5'd0) begin
                checkOutput("busyRun", 32'(busy), 32'd1);
            end
            if (doneCnt > 0) begin
                extra++;
                checkOutput("busyAfter", 32'(busy), 32'd0);
            end
            if (done) begin
                doneCnt++;
                doneIdx = idx;
                checkOutput("busyAtDone", 32'(busy), 32'd0);
            end
        end

        checkOutput("doneCount", 32'(doneCnt), 32'd1);
        checkOutput("wordCount", 32'(got), 32'(v.expWords));
        checkOutput("issueCount", 32'(issued), 32'(v.expWords));
        if (v.expWords > 0) begin
            checkOutput("firstData", 32'(firstData), 32'(v.expFirst));
            checkOutput("lastData", 32'(lastData), 32'(v.expLast));
            checkOutput("firstEnLatency", 32'(firstEnIdx), 32'd1);
            checkOutput("doneAfterLast", 32'(doneIdx), 32'(lastHsIdx + 1));
            if (!v.randReady) begin
                checkOutput("firstValidLatency", 32'(firstValidIdx), 32'd3);
                checkOutput("noGaps", 32'(lastHsIdx - firstHsIdx), 32'(v.expWords - 1));
            end
        end else begin
            checkOutput("zeroLenDone", 32'(doneIdx), 32'd1);
            checkOutput("zeroLenValid", 32'(firstValidIdx), 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        int got;
        int waitCycles;
        vec_t after;

        errors = 0;
        checks = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = 4'd0;
        len        = 5'd0;
        m_ready    = 1'b0;
        loadMemory(1'b1);

        // Commands with hand-computed first/last words (data = addr ^ 5A
        // unless fillXor=0, which puts AA/BB/CC at addresses 0..2).
        vecs[0] = '{fillXor: 1'b0, startAddr: 4'd0,  len: 5'd3,  randReady: 1'b0,
                    secondAt: 0, expWords: 3,  expFirst: 8'hAA, expLast: 8'hCC};
        vecs[1] = '{fillXor: 1'b1, startAddr: 4'd0,  len: 5'd16, randReady: 1'b0,
                    secondAt: 0, expWords: 16, expFirst: 8'h5A, expLast: 8'h55};
        vecs[2] = '{fillXor: 1'b1, startAddr: 4'd14, len: 5'd4,  randReady: 1'b0,
                    secondAt: 0, expWords: 4,  expFirst: 8'h54, expLast: 8'h5B};
        vecs[3] = '{fillXor: 1'b1, startAddr: 4'd2,  len: 5'd8,  randReady: 1'b1,
                    secondAt: 0, expWords: 8,  expFirst: 8'h58, expLast: 8'h53};
        vecs[4] = '{fillXor: 1'b1, startAddr: 4'd7,  len: 5'd0,  randReady: 1'b0,
                    secondAt: 1, expWords: 0,  expFirst: 8'h00, expLast: 8'h00};
        vecs[5] = '{fillXor: 1'b1, startAddr: 4'd5,  len: 5'd5,  randReady: 1'b0,
                    secondAt: 2, expWords: 5,  expFirst: 8'h5F, expLast: 8'h53};

        #12;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetRamEn", 32'(ram_en), 32'd0);
        checkOutput("resetRamWe", 32'(ram_we), 32'd0);
        checkOutput("resetValid", 32'(m_valid), 32'd0);
        checkOutput("resetData", 32'(m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] command %0d: addr=%0d len=%0d", i, vecs[i].startAddr, vecs[i].len);
            applyStimulus(vecs[i]);
        end

        // Reset mid-command after two words, then a fresh command.
        $display("[TB] reset mid-command");
        loadMemory(1'b1);
        @(negedge clk);
        start      = 1'b1;
        start_addr = 4'd0;
        len        = 5'd8;
        m_ready    = 1'b1;
        got        = 0;
        waitCycles = 0;
        while (got < 2 && waitCycles < 20) begin
            @(negedge clk);
            start = 1'b0;
            waitCycles++;
            #1;
            if (m_valid && m_ready) got++;
        end
        checkOutput("preResetWords", 32'(got), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncBusy", 32'(busy), 32'd0);
        checkOutput("asyncDone", 32'(done), 32'd0);
        checkOutput("asyncRamEn", 32'(ram_en), 32'd0);
        checkOutput("asyncValid", 32'(m_valid), 32'd0);
        checkOutput("asyncLast", 32'(m_last), 32'd0);
        checkOutput("asyncData", 32'(m_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        after = '{fillXor: 1'b1, startAddr: 4'd3, len: 5'd2, randReady: 1'b0,
                  secondAt: 0, expWords: 2, expFirst: 8'h59, expLast: 8'h5E};
        applyStimulus(after);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
